// File: rtl/up2_ram_if.sv
`default_nettype none
// =====================================================================
// up2_ram_if : request/acknowledge bus between the up2 swap unit and
//              the up2_ram responder.
// Revision   : 1.0
// =====================================================================
interface up2_ram_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
);
  logic                  i_read_req;
  logic                  i_write_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_read_ack;
  logic                  o_write_ack;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_busy;

  modport master (
    output i_read_req, i_write_req, i_addr, i_data,
    input  o_read_ack, o_write_ack, o_data, o_busy
  );

  modport slave (
    input  i_read_req, i_write_req, i_addr, i_data,
    output o_read_ack, o_write_ack, o_data, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/up2_ram.sv
`default_nettype none
// =====================================================================
// up2_ram  : single-port synchronous RAM serving the up2 read/write
//            handshakes with WAIT_STATES cycles of extra latency.
//            Define UP2_RAM_CLR_EN to zero the array after every reset.
// Revision : 1.0
// =====================================================================
module up2_ram #(
  parameter int ADDR_NIBBLES = 1,
  parameter int DATA_NIBBLES = 1,
  parameter int ADDR_WIDTH   = 4 * ADDR_NIBBLES,
  parameter int DATA_WIDTH   = 4 * DATA_NIBBLES,
  parameter int DEPTH        = 1 << ADDR_WIDTH,
  parameter int WAIT_STATES  = 0
) (
  input wire       clk,
  input wire       nRst,
  up2_ram_if.slave bus
);
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_ACK  = 2'd2;
`ifdef UP2_RAM_CLR_EN
  localparam logic [1:0] c_CLEAR     = 2'd3;
  localparam logic [1:0] c_RST_STATE = c_CLEAR;
`else
  localparam logic [1:0] c_RST_STATE = c_IDLE;
`endif
  localparam logic       c_OP_READ   = 1'b0;
  localparam logic       c_OP_WRITE  = 1'b1;
  localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_idle;
  logic                  w_req;
  logic                  w_op;
  logic                  w_enter_ack;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_read_ack;
  logic                  w_write_ack;
  logic                  w_busy;

  assign w_idle = (r_state == c_IDLE);
  assign w_req  = bus.i_read_req | bus.i_write_req;

  // In IDLE the live request is used so a zero-wait op can commit on its acceptance edge.
  assign w_op        = w_idle ? (bus.i_read_req ? c_OP_READ : c_OP_WRITE) : r_op;
  assign w_addr      = w_idle ? bus.i_addr : r_addr;
  assign w_wdata     = w_idle ? bus.i_data : r_wdata;
  assign w_enter_ack = nRst && (w_state_nxt == c_ACK);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= c_RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_req) begin
          w_state_nxt = (WAIT_STATES == 0) ? c_ACK : c_WAIT;
        end
      end
      c_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = c_ACK;
        end
      end
      c_ACK: w_state_nxt = c_IDLE;
`ifdef UP2_RAM_CLR_EN
      c_CLEAR: begin
        if (r_addr == ADDR_WIDTH'(DEPTH - 1)) begin
          w_state_nxt = c_IDLE;
        end
      end
`endif
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_read_ack  = 1'b0;
    w_write_ack = 1'b0;
    w_busy      = (r_state != c_IDLE);
    if (r_state == c_ACK) begin
      w_read_ack  = (r_op == c_OP_READ);
      w_write_ack = (r_op == c_OP_WRITE);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt   <= '0;
      r_op    <= c_OP_READ;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_idle && w_req) begin
        r_op   <= w_op;
        r_addr <= bus.i_addr;
        r_cnt  <= c_WAIT_INIT;
        if (w_op == c_OP_WRITE) begin
          r_wdata <= bus.i_data;
        end
      end else if (r_state == c_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
`ifdef UP2_RAM_CLR_EN
      else if (r_state == c_CLEAR) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
`endif
      if (w_enter_ack && (w_op == c_OP_READ)) begin
        r_rdata <= r_mem[w_addr];
      end
    end
  end

  // Array has no reset; contents survive nRst unless the clear sweep is built in.
  always_ff @(posedge clk) begin
    if (w_enter_ack && (w_op == c_OP_WRITE)) begin
      r_mem[w_addr] <= w_wdata;
    end
`ifdef UP2_RAM_CLR_EN
    else if (nRst && (r_state == c_CLEAR)) begin
      r_mem[r_addr] <= '0;
    end
`endif
  end

  assign bus.o_read_ack  = w_read_ack;
  assign bus.o_write_ack = w_write_ack;
  assign bus.o_busy      = w_busy;
  assign bus.o_data      = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_up2_ram.sv
`default_nettype none
// =====================================================================
// tb_up2_ram : randomized handshake bench for up2_ram at 0, 3 and 5
//              wait states against an array-based reference model.
// Revision   : 1.0
// =====================================================================
module tb_up2_ram;
`ifdef UP2_RAM_CLR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic nRst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  up2_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) bus0 ();
  up2_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) bus1 ();
  up2_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) bus2 ();

  up2_ram #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .nRst(nRst), .bus(bus0));
  up2_ram #(.WAIT_STATES(3)) u_dut1 (.clk(clk), .nRst(nRst), .bus(bus1));
  up2_ram #(.WAIT_STATES(5)) u_dut2 (.clk(clk), .nRst(nRst), .bus(bus2));

  int         ws_tab [3] = '{0, 3, 5};
  int         sel;
  logic       rreq, wreq;
  logic [3:0] addr, wdata;

  assign bus0.i_read_req  = (sel == 0) && rreq;
  assign bus0.i_write_req = (sel == 0) && wreq;
  assign bus1.i_read_req  = (sel == 1) && rreq;
  assign bus1.i_write_req = (sel == 1) && wreq;
  assign bus2.i_read_req  = (sel == 2) && rreq;
  assign bus2.i_write_req = (sel == 2) && wreq;
  assign bus0.i_addr = addr;
  assign bus1.i_addr = addr;
  assign bus2.i_addr = addr;
  assign bus0.i_data = wdata;
  assign bus1.i_data = wdata;
  assign bus2.i_data = wdata;

  logic       w_rack, w_wack, w_busy;
  logic [3:0] w_rdata;
  always_comb begin
    w_rack  = bus0.o_read_ack;
    w_wack  = bus0.o_write_ack;
    w_busy  = bus0.o_busy;
    w_rdata = bus0.o_data;
    if (sel == 1) begin
      w_rack  = bus1.o_read_ack;
      w_wack  = bus1.o_write_ack;
      w_busy  = bus1.o_busy;
      w_rdata = bus1.o_data;
    end else if (sel == 2) begin
      w_rack  = bus2.o_read_ack;
      w_wack  = bus2.o_write_ack;
      w_busy  = bus2.o_busy;
      w_rdata = bus2.o_data;
    end
  end

  // Reference model: one plain array per instance plus its last read value.
  logic [3:0] mdl_mem [3][16];
  logic [3:0] mdl_rd  [3];
  int         n_ops = 0;
  int         mon_acks = 0;
  always @(negedge clk) mon_acks <= mon_acks + int'(w_rack) + int'(w_wack);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d cyc=%0d)", tag, got, exp, sel, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 3; s++) begin
      mdl_rd[s] = 4'h0;
      if (CLR) begin
        for (int a = 0; a < 16; a++) mdl_mem[s][a] = 4'h0;
      end
    end
  endtask

  // pre = cycles from now until the DUT's first IDLE cycle that sees the request.
  task automatic op(input bit wr, input logic [3:0] a, input logic [3:0] d, input int pre);
    int t_idle;
    int t_ack;
    bit done;
    t_idle = cyc + pre;
    t_ack  = t_idle + 1 + ws_tab[sel];
    addr   = a;
    if (wr) begin
      wdata = d;
      wreq  = 1'b1;
    end else begin
      rreq = 1'b1;
    end
    done = 1'b0;
    for (int k = 0; k < pre + 40 && !done; k++) begin
      @(negedge clk);
      if (w_rack || w_wack) begin
        done = 1'b1;
        if (wr) mdl_mem[sel][a] = d;
        else    mdl_rd[sel] = mdl_mem[sel][a];
        n_ops++;
        chk("ack_cycle", cyc, t_ack);
        chk("ack_kind", {w_rack, w_wack}, wr ? 2'b01 : 2'b10);
        chk("busy_ack", w_busy, 1'b1);
        chk("rdata", w_rdata, mdl_rd[sel]);
        if (wr) wreq = 1'b0;
        else    rreq = 1'b0;
      end else begin
        chk("busy", w_busy, cyc != t_idle);
        chk("rdata_hold", w_rdata, mdl_rd[sel]);
      end
    end
    if (!done) begin
      chk("ack_timeout", 0, 1);
      rreq = 1'b0;
      wreq = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ra, rd;
    bit         rw, chain;
    int         base, ops_base;
    logic [3:0] old;

    rreq = 1'b0; wreq = 1'b0; addr = '0; wdata = '0; sel = 0; nRst = 1'b1;
    #3 nRst = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_busy0", bus0.o_busy, CLR);
    chk("rst_busy1", bus1.o_busy, CLR);
    chk("rst_busy2", bus2.o_busy, CLR);
    chk("rst_acks", {bus0.o_read_ack, bus0.o_write_ack, bus1.o_read_ack,
                     bus1.o_write_ack, bus2.o_read_ack, bus2.o_write_ack}, 0);
    chk("rst_data", {bus0.o_data, bus1.o_data, bus2.o_data}, 0);
    step();
    nRst = 1'b1;

`ifdef UP2_RAM_CLR_EN
    op(1'b0, 4'hF, 4'h0, 16);
    for (int a = 0; a < 16; a++) begin
      step();
      op(1'b0, 4'(a), 4'h0, 0);
    end
`endif

    for (int s = 0; s < 3; s++) begin
      sel = s;
      step();
      base = mon_acks;
      ops_base = n_ops;
      for (int a = 0; a < 16; a++) begin
        op(1'b1, 4'(a), 4'($urandom), 0);
        step();
      end
      op(1'b1, 4'h3, 4'hA, 0);
      step();
      op(1'b0, 4'h3, 4'h0, 0);
      step();
      // Simultaneous requests: read wins, write follows after the turnaround.
      op(1'b1, 4'h5, 4'h7, 0);
      step();
      wdata = 4'h2;
      wreq  = 1'b1;
      op(1'b0, 4'h5, 4'h0, 0);
      op(1'b1, 4'h5, 4'h2, 1);
      step();
      op(1'b0, 4'h5, 4'h0, 0);
      // Swap-unit pattern: next request raised inside the ack cycle.
      op(1'b0, 4'h9, 4'h0, 1);
      op(1'b1, 4'h9, 4'hC, 1);
      op(1'b0, 4'h9, 4'h0, 1);
      chk("swap_data", w_rdata, 4'hC);
      chain = 1'b0;
      step();
      for (int i = 0; i < 24; i++) begin
        rw = 1'($urandom);
        ra = 4'($urandom);
        rd = 4'($urandom);
        op(rw, ra, rd, chain ? 1 : 0);
        chain = 1'($urandom);
        if (!chain) repeat ($urandom_range(1, 3)) step();
      end
      if (chain) step();
      repeat (4) step();
      chk("ack_count", mon_acks - base, n_ops - ops_base);
    end

    // Reset while a write sits in WAIT: op is dropped, array keeps old value.
    sel = 2;
    step();
    base  = mon_acks;
    old   = mdl_mem[2][1];
    addr  = 4'h1;
    wdata = ~old;
    wreq  = 1'b1;
    repeat (3) @(negedge clk);
    nRst = 1'b0;
    #1;
    chk("midrst_busy", w_busy, CLR);
    chk("midrst_ack", {w_rack, w_wack}, 2'b00);
    wreq = 1'b0;
    clear_model();
    step();
    nRst = 1'b1;
    repeat (20) step();
    chk("midrst_idle", w_busy, 1'b0);
    chk("midrst_noack", mon_acks - base, 0);
    chk("midrst_data", w_rdata, 4'h0);
    op(1'b0, 4'h1, 4'h0, 0);
    chk("midrst_keep", w_rdata, CLR ? 4'h0 : old);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/up2_ram.md
Name: up2_ram

Overview:
- Single-port synchronous RAM responder that sits directly downstream of the up2 swap unit and serves its read_req/read_ack and write_req/write_ack handshakes.
- Holds 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Returns read data in the ack cycle, with a configurable number of wait states.
- Doubles as the bench memory model and as the synthesizable on-chip store for the up2 design.

Parameters:
- ADDR_NIBBLES, 1, address width in nibbles.
- DATA_NIBBLES, 1, data width in nibbles.
- ADDR_WIDTH, 4*ADDR_NIBBLES, address bits.
- DATA_WIDTH, 4*DATA_NIBBLES, data bits.
- DEPTH, 1<<ADDR_WIDTH, number of words.
- WAIT_STATES, 0, extra cycles between request acceptance and ack; legal 0..15.

Ports:
- clk  input  1  clock, rising edge.
- nRst  input  1  reset, asynchronous, active-low.
- i_read_req  input  1  read request, held by requester until ack.
- o_read_ack  output  1  one-cycle read acknowledge; o_data valid this cycle.
- i_write_req  input  1  write request, held by requester until ack.
- o_write_ack  output  1  one-cycle write acknowledge; write committed.
- i_addr  input  ADDR_WIDTH  word address, stable while a req is high.
- i_data  input  DATA_WIDTH  write data, stable while i_write_req is high.
- o_data  output  DATA_WIDTH  registered read data.
- o_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: asynchronous on nRst low.
  - state=IDLE; o_read_ack=0, o_write_ack=0, o_data=0, o_busy=0; wait counter=0.
  - Array contents are not reset (see optional feature).
- States:
  - IDLE, WAIT, ACK; 2-bit encoding.
  - 4-bit wait counter; a 1-bit op flag records read or write.
- IDLE:
  - If i_read_req: latch i_addr, op=READ.
  - Else if i_write_req: latch i_addr and i_data, op=WRITE.
  - Then go to WAIT with counter=WAIT_STATES, or straight to ACK when WAIT_STATES=0.
  - No request: stay in IDLE.
- Simultaneous read and write req in IDLE: read wins. The write stays pending and is accepted on the first IDLE cycle after the read ack.
- WAIT: decrement the counter each cycle; go to ACK on the edge where the counter reaches 1.
- Entry into ACK (same edge):
  - READ: o_data <= mem[latched addr].
  - WRITE: mem[latched addr] <= latched data.
- ACK:
  - Exactly one of o_read_ack/o_write_ack is high, for exactly one cycle.
  - Next state is always IDLE.
- Latency: request first seen high in IDLE at cycle N → ack in cycle N+1+WAIT_STATES.
- Minimum spacing between two acks is 2 cycles; the IDLE turnaround is mandatory.
- Requests are ignored in ACK. The up2 swap unit raises its next request combinationally in the ack cycle; that request is sampled in the following IDLE cycle, never double-counted.
- o_data holds its last read value through writes and idle cycles; it changes only on entry into ACK for a read.
- A request dropped before ack (protocol violation) does not abort the operation; the ack is still issued.
- Address wrap: full ADDR_WIDTH decode; no out-of-range addresses exist.
- Reset mid-operation: the pending op is discarded; no ack follows reset.
  - A write committed on the ACK-entry edge before reset is retained.
  - A write still in WAIT is lost.

Optional Feature:
- Macro: UP2_RAM_CLR_EN.
- Defined:
  - After nRst deasserts, the block runs a CLEAR state writing 0 to addresses 0..DEPTH-1, one per cycle, ascending.
  - o_busy is high throughout; requests are not accepted and not acked.
  - The block enters IDLE on the cycle after address DEPTH-1 is written, so the clear takes DEPTH cycles.
  - Reset during the clear restarts it from address 0.
- Undefined: no CLEAR state. The block enters IDLE immediately after reset, and contents are undefined at power-up and preserved across reset.

Test Plan:
- WAIT_STATES=0. Write 0xA to addr 0x3, then read addr 0x3 → o_write_ack 1 cycle after req; read ack 1 cycle after read req with o_data=0xA; o_busy high 1 cycle for each op.
- WAIT_STATES=3. Read req at cycle 10 → o_read_ack only in cycle 14; o_busy high cycles 11-14; o_data unchanged until 14.
- Read and write req both high in IDLE, addr 0x5, prior content 0x7, write data 0x2 → read ack first with o_data=0x7; write ack 2 cycles later; subsequent read of 0x5 returns 0x2.
- Drive up2 swap-unit pattern: read(0x9) → write(0x9, 0xC) raised in the read-ack cycle → read(0x9) → exactly 3 acks, none duplicated; final o_data=0xC.
- WAIT_STATES=5. Pulse nRst low during WAIT of a write to 0x1 → no ack; o_busy=0 after reset; addr 0x1 keeps its old value.
- With UP2_RAM_CLR_EN. Release reset, hold i_read_req on addr 0xF → no ack for 16 cycles; ack next available with o_data=0x0; all 16 addresses read back 0x0.
